// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode/operand-select stage feeding the integer ALU (option macro: ID_WB_BYPASS_EN)
module id_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_x,
  output logic [31:0]      out_y,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        accept;

  logic [31:0] dec_x;
  logic [31:0] dec_y;
  logic [2:0]  dec_f3;
  logic [6:0]  dec_f7;
  logic        dec_legal;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // A stalled output register blocks new input; a consumed one frees the slot this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

`ifdef ID_WB_BYPASS_EN
  // Forward the in-flight writeback; x0 never matches because wb_rd must be nonzero.
  always_comb begin
    rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
    rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) rs1_val = wb_data;
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) rs2_val = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_rd, wb_data};

  // Operands come straight from the regfile, with x0 forced to zero.
  always_comb begin
    rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
    rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;
  end
`endif

  // Decode into the ALU's operand/function encoding; illegal encodings collapse to all-zero.
  always_comb begin
    dec_x     = 32'd0;
    dec_y     = 32'd0;
    dec_f3    = 3'd0;
    dec_f7    = 7'd0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_x     = rs1_val;
        dec_y     = rs2_val;
        dec_f3    = funct3;
        dec_f7    = funct7;
        dec_legal = (funct7 == 7'd0) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec_x  = rs1_val;
        dec_y  = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_f3 = funct3;
        // Only shifts carry funct7 through; otherwise ADDI with imm[11:5]=0x20 would read as SUB.
        dec_f7 = (funct3 == 3'b101) ? funct7 : 7'd0;
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'd0);
          3'b101:  dec_legal = (funct7 == 7'd0) || (funct7 == 7'h20);
          default: dec_legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_y     = {in_instr[31:12], 12'd0};
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_x     = in_pc;
        dec_y     = {in_instr[31:12], 12'd0};
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_x  = 32'd0;
      dec_y  = 32'd0;
      dec_f3 = 3'd0;
      dec_f7 = 7'd0;
    end
  end

  // Output register with valid/ready handshake, flush kill and saturating illegal counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_x       <= 32'd0;
      out_y       <= 32'd0;
      out_funct3  <= 3'd0;
      out_funct7  <= 7'd0;
      out_rd      <= 5'd0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_x       <= dec_x;
      out_y       <= dec_y;
      out_funct3  <= dec_f3;
      out_funct7  <= dec_f7;
      out_rd      <= rd;
      out_we      <= dec_legal && (rd != 5'd0);
      out_illegal <= !dec_legal;
      if (!dec_legal && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
